// File: rtl/div_scheduler_pkg.sv
// Shared synth datapath definitions for the divider scheduler.
package synth_pkg;

  localparam int unsigned DIV_OPND_W = 16;
  localparam int unsigned DIV_QUOT_W = 8;

  localparam logic [DIV_QUOT_W-1:0] DIV_ZERO_RESULT    = 8'hFF;
  localparam logic [DIV_QUOT_W-1:0] DIV_TIMEOUT_RESULT = 8'h00;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivLoad = 2'd1,
    DivWait = 2'd2,
    DivResp = 2'd3
  } div_sched_state_t;

endpackage

// File: rtl/div_scheduler_if.sv
// Requester-side and divider-side signals of the divider scheduler.
interface div_scheduler_if
  import synth_pkg::*;
#(
  parameter int unsigned NREQ = 4
);

  localparam int unsigned IdW = $clog2(NREQ);

  // Requester side
  logic [NREQ-1:0]            req_i;
  logic [NREQ*DIV_OPND_W-1:0] dividend_i;
  logic [NREQ*DIV_OPND_W-1:0] divisor_i;
  logic [NREQ-1:0]            ack_o;
  logic [DIV_QUOT_W-1:0]      result_o;
  logic                       err_o;
  logic                       busy_o;
  logic [IdW-1:0]             grant_id_o;

  // Divider side
  logic                       div_load_o;
  logic [DIV_OPND_W-1:0]      div_dividend_o;
  logic [DIV_OPND_W-1:0]      div_divisor_o;
  logic                       div_done_i;
  logic [DIV_QUOT_W-1:0]      div_quotient_i;

  // The scheduler itself
  modport slave (
    input  req_i, dividend_i, divisor_i, div_done_i, div_quotient_i,
    output ack_o, result_o, err_o, busy_o, grant_id_o,
    output div_load_o, div_dividend_o, div_divisor_o
  );

  // Requesters plus divider, i.e. the environment around the scheduler
  modport master (
    output req_i, dividend_i, divisor_i, div_done_i, div_quotient_i,
    input  ack_o, result_o, err_o, busy_o, grant_id_o,
    input  div_load_o, div_dividend_o, div_divisor_o
  );

endinterface

// File: rtl/div_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic                    gnt_valid_o,
  output logic [$clog2(NREQ)-1:0] gnt_id_o
);

  localparam int unsigned IdW = $clog2(NREQ);

  // Walk NREQ slots starting at ptr_i; the first hit wins.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_valid_o && req_i[IdW'(idx)]) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// Shares one sequential divider among NREQ requesters: round-robin grant, operand
// latch, divide-by-zero bypass and a completion watchdog.
module div_scheduler
  import synth_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           n_rst,
  div_scheduler_if.slave bus_io
);

  localparam int unsigned IdW = $clog2(NREQ);
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] StIdle = DivIdle;
  localparam logic [1:0] StLoad = DivLoad;
  localparam logic [1:0] StWait = DivWait;
  localparam logic [1:0] StResp = DivResp;

  logic [1:0]            state_q, state_d;
  logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]        gid_q, gid_d;
  logic [DIV_OPND_W-1:0] dvd_q, dvd_d;
  logic [DIV_OPND_W-1:0] dvs_q, dvs_d;
  logic [DIV_QUOT_W-1:0] res_q, res_d;
  logic                  err_q, err_d;
  logic [WdW-1:0]        wdog_q, wdog_d;

  logic                  gnt_valid;
  logic [IdW-1:0]        gnt_id;
  logic [DIV_OPND_W-1:0] sel_dvd;
  logic [DIV_OPND_W-1:0] sel_dvs;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req_i      (bus_io.req_i),
    .ptr_i      (rr_ptr_q),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );

  // Pick the winner's operand slices out of the packed requester buses.
  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt_id == IdW'(k)) begin
        sel_dvd = bus_io.dividend_i[k*DIV_OPND_W +: DIV_OPND_W];
        sel_dvs = bus_io.divisor_i[k*DIV_OPND_W +: DIV_OPND_W];
      end
    end
  end

  // FSM next state, operand/result latching and watchdog.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d    = gid_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    res_d    = res_q;
    err_d    = err_q;
    wdog_d   = wdog_q;
    case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          gid_d = gnt_id;
          dvd_d = sel_dvd;
          dvs_d = sel_dvs;
          // A zero divisor never reaches the divider.
          if (sel_dvs == '0) begin
            res_d   = DIV_ZERO_RESULT;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        // Any done seen here belongs to nothing we issued; ignore it.
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        // Done takes priority over a simultaneous watchdog expiry.
        if (bus_io.div_done_i) begin
          res_d   = bus_io.div_quotient_i;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
          res_d   = DIV_TIMEOUT_RESULT;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          wdog_d = wdog_q + WdW'(1);
        end
      end
      StResp: begin
        rr_ptr_d = (gid_q == IdW'(NREQ - 1)) ? '0 : gid_q + IdW'(1);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      res_q    <= res_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  // Acknowledge decoded from registered state only.
  always_comb begin
    bus_io.ack_o = '0;
    if (state_q == StResp) bus_io.ack_o[gid_q] = 1'b1;
  end

  assign bus_io.result_o       = (state_q == StResp) ? res_q : '0;
  assign bus_io.err_o          = (state_q == StResp) && err_q;
  assign bus_io.busy_o         = (state_q != StIdle);
  assign bus_io.grant_id_o     = gid_q;
  assign bus_io.div_load_o     = (state_q == StLoad);
  assign bus_io.div_dividend_o = dvd_q;
  assign bus_io.div_divisor_o  = dvs_q;

endmodule
